iram_loader: RTL and testbench



---
 rtl/hxd32_pkg.sv | 17 +
 rtl/iram_loader_if.sv | 35 +++
 rtl/iram_loader_asm.sv | 41 ++++
 rtl/iram_loader.sv | 147 ++++++++++++++
 tb/tb_iram_loader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hxd32_pkg.sv
// Shared hxd32 definitions used by the boot-time IRAM loader.
// Holds the loader FSM states and its frame and byte-enable constants.
package hxd32_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam logic [3:0] WR_WORD      = 4'b1111;

endpackage

// File: rtl/iram_loader_if.sv
// Host byte stream plus IRAM write port of the loader.
// The master is the host link side; the slave is the loader.
interface iram_loader_if #(
    parameter int XLEN = 32
);

    logic            byte_valid_i;
    logic [7:0]      byte_data_i;
    logic            byte_ready_o;
    logic            iram_wr_en_o;
    logic [XLEN-1:0] iram_wr_addr_o;
    logic [XLEN-1:0] iram_wr_data_o;
    logic [3:0]      iram_wr_byte_en_o;

    modport master (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  iram_wr_en_o,
        input  iram_wr_addr_o,
        input  iram_wr_data_o,
        input  iram_wr_byte_en_o
    );

    modport slave (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output iram_wr_en_o,
        output iram_wr_addr_o,
        output iram_wr_data_o,
        output iram_wr_byte_en_o
    );

endinterface

// File: rtl/iram_loader_asm.sv
// Byte-to-word assembler: little-endian lane fill plus payload checksum.
// word/word_valid present the completed word alongside the 4th byte strobe.
module iram_loader_asm (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        strobe,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  sum
);

    logic [1:0]  cnt;
    logic [23:0] lanes;

    assign word_valid = strobe && (cnt == 2'd3);
    assign word       = {data, lanes};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt   <= '0;
            lanes <= '0;
            sum   <= '0;
        end else if (clear) begin
            cnt   <= '0;
            lanes <= '0;
            sum   <= '0;
        end else if (strobe) begin
            cnt <= cnt + 2'd1;
            sum <= sum + data;
            unique case (cnt)
                2'd0:    lanes[7:0]   <= data;
                2'd1:    lanes[15:8]  <= data;
                2'd2:    lanes[23:16] <= data;
                default: lanes        <= '0;
            endcase
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Boot-time IRAM loader: parses MAGIC/LEN/payload/CSUM frames,
// writes words to IRAM and holds the core in reset until a good frame.
module iram_loader
    import hxd32_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          IRAM_DEPTH = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [7:0]  MAGIC      = LOADER_MAGIC
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    iram_loader_if.slave        bus,
    output logic                cpu_rst_n_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam logic [16:0] DEPTH = 17'(IRAM_DEPTH);

    loader_state_t state;
    logic          booted;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [15:0]   idx;

    logic          fire;
    logic [7:0]    b;
    logic [15:0]   len_n;
    logic          asm_strobe;
    logic          asm_clear;
    logic          word_valid;
    logic [31:0]   word;
    logic [7:0]    sum;

    assign fire  = bus.byte_valid_i && bus.byte_ready_o;
    assign b     = bus.byte_data_i;
    assign len_n = {b, len_lo};

    assign asm_strobe = fire && (state == DATA);
    assign asm_clear  = fire && ((state == LEN_HI) || (state == CSUM));

    iram_loader_asm u_asm (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .strobe     (asm_strobe),
        .clear      (asm_clear),
        .data       (b),
        .word_valid (word_valid),
        .word       (word),
        .sum        (sum)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state                 <= IDLE;
            booted                <= 1'b0;
            len_lo                <= '0;
            len                   <= '0;
            idx                   <= '0;
            bus.byte_ready_o      <= 1'b0;
            bus.iram_wr_en_o      <= 1'b0;
            bus.iram_wr_addr_o    <= '0;
            bus.iram_wr_data_o    <= '0;
            bus.iram_wr_byte_en_o <= '0;
            cpu_rst_n_o           <= 1'b0;
            busy_o                <= 1'b0;
            done_o                <= 1'b0;
            err_o                 <= 1'b0;
        end else begin
            bus.byte_ready_o      <= 1'b1;
            bus.iram_wr_en_o      <= 1'b0;
            bus.iram_wr_byte_en_o <= '0;
            done_o                <= 1'b0;
            // Out of reset the core runs whatever IRAM already holds.
            if (!booted) begin
                booted      <= 1'b1;
                cpu_rst_n_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (fire && (b == MAGIC)) begin
                        state       <= LEN_LO;
                        cpu_rst_n_o <= 1'b0;
                        busy_o      <= 1'b1;
                        err_o       <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (fire) begin
                        len_lo <= b;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (fire) begin
                        len <= len_n;
                        idx <= '0;
                        if ({1'b0, len_n} > DEPTH) begin
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else if (len_n == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        state                 <= WRITE;
                        bus.byte_ready_o      <= 1'b0;
                        bus.iram_wr_en_o      <= 1'b1;
                        bus.iram_wr_byte_en_o <= WR_WORD;
                        bus.iram_wr_addr_o    <= XLEN'(BASE_ADDR)
                                               + (XLEN'(idx) << 2);
                        bus.iram_wr_data_o    <= XLEN'(word);
                    end
                end
                WRITE: begin
                    idx <= idx + 16'd1;
                    if ((idx + 16'd1) == len) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA;
                    end
                end
                CSUM: begin
                    if (fire) begin
                        if (b == sum) begin
                            done_o      <= 1'b1;
                            cpu_rst_n_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: framing, checksum, length limit,
// streaming back-pressure and asynchronous reset mid-frame.
module tb_iram_loader;
    import hxd32_pkg::*;

    logic clk;
    logic rst_n;
    logic cpu_rst_n;
    logic busy;
    logic done;
    logic err;

    int vectors;
    int miscompares;
    int done_cnt;
    int rdy_low;
    bit mon_en;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wb[$];

    iram_loader_if #(.XLEN(32)) bus ();

    iram_loader #(
        .XLEN       (32),
        .IRAM_DEPTH (4096),
        .BASE_ADDR  (32'h0000_0000),
        .MAGIC      (8'hA5)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (bus),
        .cpu_rst_n_o (cpu_rst_n),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.iram_wr_en_o) begin
            wa.push_back(bus.iram_wr_addr_o);
            wd.push_back(bus.iram_wr_data_o);
            wb.push_back(bus.iram_wr_byte_en_o);
        end
        if (done) done_cnt++;
        if (mon_en && !bus.byte_ready_o) rdy_low++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte and return just after the posedge that takes it.
    task automatic send(input logic [7:0] v);
        int t = 0;
        @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = v;
        while (!bus.byte_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_bytes();
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic clr_mon();
        wa.delete();
        wd.delete();
        wb.delete();
        done_cnt = 0;
        rdy_low  = 0;
    endtask

    task automatic send_frame_a(input logic [7:0] cs);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(cs);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mon_en = 1'b0;
        clr_mon();
        rst_n = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.byte_ready_o), 64'd0);
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("rst_wr", 64'({bus.iram_wr_en_o, bus.iram_wr_byte_en_o}),
              64'd0);
        check("rst_addr_data",
              64'({bus.iram_wr_addr_o, bus.iram_wr_data_o}), 64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("boot_ready", 64'(bus.byte_ready_o), 64'd1);
        check("boot_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        repeat (3) @(negedge clk);
        check("idle_writes", 64'(wa.size()), 64'd0);
        check("idle_cpu_rst_n", 64'(cpu_rst_n), 64'd1);

        // Good two-word frame; payload sum is 0x4C.
        clr_mon();
        send(8'hA5);
        check("a_magic_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("a_magic_busy", 64'(busy), 64'd1);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check("a_pre_csum_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        send(8'h4C);
        check("a_done", 64'(done), 64'd1);
        check("a_release", 64'(cpu_rst_n), 64'd1);
        check("a_busy_clear", 64'(busy), 64'd0);
        stop_bytes();
        repeat (2) @(negedge clk);
        check("a_nwrites", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            check("a_w0_addr", 64'(wa[0]), 64'h0);
            check("a_w0_data", 64'(wd[0]), 64'h1234_5678);
            check("a_w0_be", 64'(wb[0]), 64'hF);
            check("a_w1_addr", 64'(wa[1]), 64'h4);
            check("a_w1_data", 64'(wd[1]), 64'hDEAD_BEEF);
            check("a_w1_be", 64'(wb[1]), 64'hF);
        end
        check("a_done_cnt", 64'(done_cnt), 64'd1);

        // Same frame, wrong checksum.
        clr_mon();
        send_frame_a(8'h00);
        stop_bytes();
        repeat (2) @(negedge clk);
        check("bad_nwrites", 64'(wa.size()), 64'd2);
        check("bad_err", 64'(err), 64'd1);
        check("bad_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("bad_no_done", 64'(done_cnt), 64'd0);

        clr_mon();
        send(8'hA5);
        check("recov_err_clear", 64'(err), 64'd0);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(8'h4C);
        stop_bytes();
        @(negedge clk);
        check("recov_release", 64'(cpu_rst_n), 64'd1);
        check("recov_done_cnt", 64'(done_cnt), 64'd1);

        // Length 0x1001 exceeds 4096 words.
        clr_mon();
        send(8'hA5); send(8'h01); send(8'h10);
        check("len_err", 64'(err), 64'd1);
        check("len_busy", 64'(busy), 64'd0);
        send(8'h33);
        check("len_idle_busy", 64'(busy), 64'd0);
        check("len_cpu_held", 64'(cpu_rst_n), 64'd0);
        stop_bytes();
        repeat (2) @(negedge clk);
        check("len_nwrites", 64'(wa.size()), 64'd0);
        check("len_err_sticky", 64'(err), 64'd1);

        // Zero-length frame: checksum of nothing is 0.
        clr_mon();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        check("zero_done", 64'(done), 64'd1);
        check("zero_release", 64'(cpu_rst_n), 64'd1);
        check("zero_err", 64'(err), 64'd0);
        stop_bytes();

        // Continuous valid during a one-word frame, sum 0xAA.
        clr_mon();
        mon_en = 1'b1;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'hAA);
        check("strm_done", 64'(done), 64'd1);
        mon_en = 1'b0;
        stop_bytes();
        @(negedge clk);
        check("strm_rdy_low", 64'(rdy_low), 64'd1);
        check("strm_nwrites", 64'(wa.size()), 64'd1);
        if (wa.size() == 1) begin
            check("strm_addr", 64'(wa[0]), 64'h0);
            check("strm_data", 64'(wd[0]), 64'h4433_2211);
        end

        // Reset after two payload bytes of a one-word frame.
        clr_mon();
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22);
        stop_bytes();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.byte_ready_o), 64'd0);
        check("mid_rst_flags", 64'({cpu_rst_n, busy, done, err}), 64'd0);
        check("mid_rst_wr", 64'({bus.iram_wr_en_o, bus.iram_wr_byte_en_o}),
              64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_nwrites", 64'(wa.size()), 64'd0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        send(8'hBA);
        check("post_rst_done", 64'(done), 64'd1);
        stop_bytes();
        @(negedge clk);
        check("post_rst_nwrites", 64'(wa.size()), 64'd1);
        if (wa.size() == 1) begin
            check("post_rst_addr", 64'(wa[0]), 64'h0);
            check("post_rst_data", 64'(wd[0]), 64'h8877_6655);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
